mips_main: RTL and testbench

//  Single-cycle 32-bit MIPS-subset core with its own 128-word instruction and data memories.
//  A load port fills both memories while the core is held; the core executes when loading stops.
//  Top-level processor block; a debug port exposes the register file and PC for checking.

---
 rtl/mips_main.sv | 131 +++++++++++++
 tb/tb_mips_main.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_main.sv
// Single-cycle 32-bit MIPS-subset core with private 128-word instruction/data memories.
// A load port fills both memories while the core is held; debug port reads registers and PC.
module mips_main (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [6:0]  instructionAddress,
   input  logic [31:0] data,
   input  logic [6:0]  dataAddress,
   input  logic        writeEnable,
   input  logic [4:0]  debugRegAddr,
   output logic [31:0] debugRegData,
   output logic [6:0]  pcOut
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;

   logic [31:0] imem [0:127];
   logic [31:0] dmem [0:127];
   logic [31:0] regs [0:31];
   logic [6:0]  pc;

   logic [31:0] ins;
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sh;
   logic [15:0] imm;

   logic signed [31:0] rs_val, rt_val, simm, sum;
   logic [31:0] zimm, wdata;
   logic [4:0]  waddr;
   logic        reg_we, mem_we;
   logic [6:0]  pc_next, maddr;

   // R-type ALU; the top bit flags a recognised funct so unknown ones fall through as NOPs.
   function automatic logic [32:0] alu_r(input logic [5:0] f,
                                         input logic signed [31:0] a,
                                         input logic signed [31:0] b,
                                         input logic [4:0] s);
      logic [32:0] r;
      case (f)
         FN_ADD:  r = {1'b1, a + b};
         FN_SUB:  r = {1'b1, a - b};
         FN_AND:  r = {1'b1, a & b};
         FN_OR:   r = {1'b1, a | b};
         FN_SLT:  r = {1'b1, 31'd0, (a < b)};
         FN_SLL:  r = {1'b1, b << s};
         default: r = {1'b0, 32'd0};
      endcase
      return r;
   endfunction

   assign ins  = imem[pc];
   assign op   = ins[31:26];
   assign rs   = ins[25:21];
   assign rt   = ins[20:16];
   assign rd   = ins[15:11];
   assign sh   = ins[10:6];
   assign fn   = ins[5:0];
   assign imm  = ins[15:0];

   assign rs_val = (rs == 5'd0) ? 32'sd0 : regs[rs];
   assign rt_val = (rt == 5'd0) ? 32'sd0 : regs[rt];
   assign simm   = {{16{imm[15]}}, imm};
   assign zimm   = {16'd0, imm};
   assign sum    = rs_val + simm;
   assign maddr  = sum[6:0];

   assign debugRegData = (debugRegAddr == 5'd0) ? 32'd0 : regs[debugRegAddr];
   assign pcOut        = pc;

   always_comb begin
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      waddr   = rt;
      wdata   = sum;
      pc_next = pc + 7'd1;
      case (op)
         OP_RTYPE: begin
            waddr           = rd;
            {reg_we, wdata} = alu_r(fn, rs_val, rt_val, sh);
         end
         OP_ADDI: reg_we = 1'b1;
         OP_ANDI: begin
            reg_we = 1'b1;
            wdata  = rs_val & zimm;
         end
         OP_LW: begin
            reg_we = 1'b1;
            wdata  = dmem[maddr];
         end
         OP_SW:  mem_we = 1'b1;
         OP_BEQ: if (rs_val == rt_val) pc_next = pc + 7'd1 + imm[6:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= 7'd0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (!writeEnable) begin
         pc <= pc_next;
         if (reg_we && waddr != 5'd0) regs[waddr] <= wdata;
      end
   end

   // Memories keep their contents through reset; only the load port or sw writes them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (writeEnable) begin
            imem[instructionAddress] <= instruction;
            dmem[dataAddress]        <= data;
         end else if (mem_we) begin
            dmem[maddr] <= rt_val;
         end
      end
   end

endmodule

// File: tb/tb_mips_main.sv
// Bench for mips_main: directed instruction table, corner sequences, and random programs
// checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_mips_main;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instruction = '0;
   logic [6:0]  instructionAddress = '0;
   logic [31:0] data = '0;
   logic [6:0]  dataAddress = '0;
   logic        writeEnable = 1'b0;
   logic [4:0]  debugRegAddr = '0;
   logic [31:0] debugRegData;
   logic [6:0]  pcOut;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_imem [128];
   logic [31:0] m_dmem [128];
   logic [31:0] m_regs [32];
   int          m_pc;

   mips_main dut (
      .clk(clk), .reset(reset), .instruction(instruction),
      .instructionAddress(instructionAddress), .data(data), .dataAddress(dataAddress),
      .writeEnable(writeEnable), .debugRegAddr(debugRegAddr),
      .debugRegData(debugRegData), .pcOut(pcOut)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] sh, logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_reg(string nm, int idx, logic [31:0] exp);
      debugRegAddr = 5'(idx);
      #0.01;
      chk($sformatf("%s r%0d", nm, idx), debugRegData, exp);
   endtask

   task automatic chk_pc(string nm, int exp);
      chk($sformatf("%s pc", nm), {25'd0, pcOut}, 32'(exp));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      writeEnable = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
   endtask

   task automatic load_word(int ia, logic [31:0] iw, int da, logic [31:0] dw);
      writeEnable = 1'b1;
      instructionAddress = 7'(ia);
      instruction = iw;
      dataAddress = 7'(da);
      data = dw;
      @(posedge clk); #1;
      writeEnable = 1'b0;
      m_imem[ia] = iw;
      m_dmem[da] = dw;
   endtask

   // Reference: execute one instruction from the decoded fields with plain arithmetic.
   task automatic m_step();
      logic [31:0] w, a, b, se, res;
      int op, fn, rs, rt, rd, sh, dst, nxt;
      bit wr;
      w  = m_imem[m_pc];
      op = int'(w >> 26); rs = int'((w >> 21) & 31); rt = int'((w >> 16) & 31);
      rd = int'((w >> 11) & 31); sh = int'((w >> 6) & 31); fn = int'(w & 63);
      a = m_regs[rs]; b = m_regs[rt];
      se = (w & 32'h8000) != 0 ? (w | 32'hFFFF0000) : (w & 32'h0000FFFF);
      nxt = (m_pc + 1) % 128;
      wr = 0; dst = rt; res = 0;
      if (op == 0) begin
         dst = rd; wr = 1;
         if      (fn == 32) res = a + b;
         else if (fn == 34) res = a - b;
         else if (fn == 36) res = a & b;
         else if (fn == 37) res = a | b;
         else if (fn == 42) res = ($signed(a) < $signed(b)) ? 1 : 0;
         else if (fn == 0)  res = b << sh;
         else wr = 0;
      end
      else if (op == 8)  begin wr = 1; res = a + se; end
      else if (op == 12) begin wr = 1; res = a & (w & 32'hFFFF); end
      else if (op == 35) begin wr = 1; res = m_dmem[(a + se) % 128]; end
      else if (op == 43) m_dmem[(a + se) % 128] = b;
      else if (op == 4 && a == b) nxt = (m_pc + 1 + int'(w & 127)) % 128;
      if (wr && dst != 0) m_regs[dst] = res;
      m_pc = nxt;
   endtask

   task automatic run_cycle();
      writeEnable = 1'b0;
      @(posedge clk); #1;
      m_step();
   endtask

   function automatic logic [31:0] rnd_ins();
      logic [4:0] rs, rt, rd, sh;
      logic [15:0] imm;
      logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
      int k;
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7)); sh = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      k = int'($urandom_range(0, 12));
      if (k < 6)   return enc_r(rs, rt, rd, sh, fns[k]);
      if (k == 6)  return enc_i(6'h08, rs, rt, imm);
      if (k == 7)  return enc_i(6'h0C, rs, rt, imm);
      if (k == 8)  return enc_i(6'h23, rs, rt, imm);
      if (k == 9)  return enc_i(6'h2B, rs, rt, imm);
      if (k == 10) return enc_i(6'h04, rs, rt, imm);
      if (k == 11) return enc_i(6'h3F, rs, rt, imm);
      return enc_r(rs, rt, rd, sh, 6'h3F);
   endfunction

   typedef struct {
      int          addr;
      logic [31:0] ins;
      int          r;
      logic [31:0] val;
      int          pc;
   } vec_t;

   vec_t tbl [20];

   initial begin
      int nv;
      nv = 0;
      tbl[nv++] = '{0,  enc_i(6'h08, 0, 1, 16'd12),     1,  32'd12,       1};
      tbl[nv++] = '{1,  enc_i(6'h08, 0, 2, 16'd3),      2,  32'd3,        2};
      tbl[nv++] = '{2,  enc_r(2, 1, 3, 0, 6'h22),       3,  32'hFFFFFFF7, 3};
      tbl[nv++] = '{3,  enc_r(1, 2, 4, 0, 6'h2A),       4,  32'd0,        4};
      tbl[nv++] = '{4,  enc_r(0, 1, 5, 1, 6'h00),       5,  32'd24,       5};
      tbl[nv++] = '{5,  enc_r(1, 2, 6, 0, 6'h24),       6,  32'd0,        6};
      tbl[nv++] = '{6,  enc_r(1, 2, 7, 0, 6'h25),       7,  32'd15,       7};
      tbl[nv++] = '{7,  enc_i(6'h0C, 1, 8, 16'hFFFF),   8,  32'd12,       8};
      tbl[nv++] = '{8,  enc_r(1, 2, 9, 0, 6'h20),       9,  32'd15,       9};
      tbl[nv++] = '{9,  enc_r(2, 1, 10, 0, 6'h2A),      10, 32'd1,        10};
      tbl[nv++] = '{10, enc_i(6'h2B, 0, 1, 16'd5),      1,  32'd12,       11};
      tbl[nv++] = '{11, enc_i(6'h23, 0, 11, 16'd5),     11, 32'd12,       12};
      tbl[nv++] = '{12, enc_i(6'h08, 0, 0, 16'd5),      0,  32'd0,        13};
      tbl[nv++] = '{13, enc_i(6'h08, 0, 12, 16'hFFFF),  12, 32'hFFFFFFFF, 14};
      tbl[nv++] = '{14, enc_r(12, 1, 13, 0, 6'h2A),     13, 32'd1,        15};
      tbl[nv++] = '{15, enc_r(12, 12, 14, 0, 6'h20),    14, 32'hFFFFFFFE, 16};
      tbl[nv++] = '{16, enc_i(6'h3F, 0, 15, 16'd7),     15, 32'd0,        17};
      tbl[nv++] = '{17, enc_i(6'h04, 1, 11, 16'd2),     1,  32'd12,       20};
      tbl[nv++] = '{20, enc_i(6'h08, 0, 16, 16'd9),     16, 32'd9,        21};
      tbl[nv++] = '{21, enc_i(6'h04, 1, 2, 16'd5),      2,  32'd3,        22};

      // Reset state
      do_reset();
      chk_pc("reset", 0);
      for (int i = 0; i < 32; i++) chk_reg("reset", i, 32'd0);

      // Clear both memories so every fetch is a known NOP
      for (int i = 0; i < 128; i++) load_word(i, 32'd0, i, 32'd0);
      chk_pc("load hold", 0);

      // First-instruction smoke test
      load_word(0, 32'h20220003, 0, 32'd0);
      run_cycle();
      chk_reg("addi", 2, 32'd3);
      chk_pc("addi", 1);

      // lw / sw round trip
      do_reset();
      load_word(0, enc_i(6'h23, 0, 1, 16'd0), 0, 32'd12);
      load_word(1, enc_i(6'h2B, 0, 1, 16'd5), 0, 32'd12);
      load_word(2, enc_i(6'h23, 0, 2, 16'd5), 0, 32'd12);
      run_cycle(); chk_reg("lw", 1, 32'd12);
      run_cycle(); run_cycle();
      chk_reg("sw-lw", 2, 32'd12);

      // Directed instruction table
      do_reset();
      for (int i = 0; i < 128; i++) load_word(i, 32'd0, i, 32'd0);
      for (int k = 0; k < nv; k++) load_word(tbl[k].addr, tbl[k].ins, 64 + k, 32'd0);
      for (int k = 0; k < nv; k++) begin
         run_cycle();
         chk_reg($sformatf("tbl%0d", k), tbl[k].r, tbl[k].val);
         chk_pc($sformatf("tbl%0d", k), tbl[k].pc);
      end

      // Load mode holds the core for 10 clocks
      for (int i = 0; i < 10; i++) load_word(100, 32'd0, 100, 32'd0);
      chk_pc("hold10", 22);
      chk_reg("hold10", 1, 32'd12);
      chk_reg("hold10", 13, 32'd1);

      // Mid-program reset clears PC and registers, then the program reruns
      do_reset();
      chk_pc("midreset", 0);
      for (int i = 0; i < 32; i++) chk_reg("midreset", i, 32'd0);
      load_word(0, tbl[0].ins, 64, 32'd0);
      load_word(1, tbl[1].ins, 65, 32'd0);
      run_cycle(); run_cycle();
      chk_reg("rerun", 1, 32'd12);
      chk_reg("rerun", 2, 32'd3);
      chk_pc("rerun", 2);

      // beq taken from PC 0
      do_reset();
      load_word(0, 32'h1022003F, 0, 32'd0);
      run_cycle(); chk_pc("beq taken", 64);

      // beq not taken
      do_reset();
      load_word(0, enc_i(6'h08, 0, 1, 16'd1), 0, 32'd0);
      load_word(1, 32'h1022003F, 0, 32'd0);
      run_cycle(); run_cycle();
      chk_pc("beq nottaken", 2);

      // PC wrap: jump to 127, then beq imm 0 wraps to 0
      do_reset();
      load_word(0, enc_i(6'h04, 0, 0, 16'd126), 0, 32'd0);
      load_word(127, enc_i(6'h04, 0, 0, 16'd0), 0, 32'd0);
      run_cycle(); chk_pc("jump127", 127);
      run_cycle(); chk_pc("wrap", 0);

      // Random programs against the reference model
      for (int round = 0; round < 3; round++) begin
         do_reset();
         for (int i = 0; i < 128; i++) load_word(i, rnd_ins(), i, $urandom);
         for (int c = 0; c < 150; c++) begin
            run_cycle();
            chk_pc($sformatf("rnd%0d c%0d", round, c), m_pc);
         end
         for (int i = 0; i < 32; i++) chk_reg($sformatf("rnd%0d", round), i, m_regs[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
